clk_wiz: RTL and testbench



---
 rtl/clk_wiz.sv | 103 ++++++++++
 tb/tb_clk_wiz.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_wiz.sv
// Counter-based clock wizard: two 50%-duty divided clocks from clk_in1 plus a lock flag.
// Optional build macro CLK_WIZ_OUT_GATE_EN holds both dividers idle and low until locked.
module clk_wiz #(
    parameter int DIV1        = 2,
    parameter int DIV2        = 4,
    parameter int LOCK_CYCLES = 16
) (
    input  logic clk_in1,
    input  logic reset,
    output logic clk_out1,
    output logic clk_out2,
    output logic locked
);

    localparam int CNT1_W = (DIV1 / 2 > 1) ? $clog2(DIV1 / 2) : 1;
    localparam int CNT2_W = (DIV2 / 2 > 1) ? $clog2(DIV2 / 2) : 1;
    localparam logic [CNT1_W-1:0] TERM1    = CNT1_W'(DIV1 / 2 - 1);
    localparam logic [CNT2_W-1:0] TERM2    = CNT2_W'(DIV2 / 2 - 1);
    localparam logic [15:0]       LOCK_TGT = 16'(LOCK_CYCLES);

    generate
        if ((DIV1 < 2) || (DIV1 > 256) || (DIV1 % 2 != 0)) begin : g_bad_div1
            $error("clk_wiz: DIV1 must be an even integer in 2..256");
        end
        if ((DIV2 < 2) || (DIV2 > 256) || (DIV2 % 2 != 0)) begin : g_bad_div2
            $error("clk_wiz: DIV2 must be an even integer in 2..256");
        end
        if ((LOCK_CYCLES < 1) || (LOCK_CYCLES > 65535)) begin : g_bad_lock
            $error("clk_wiz: LOCK_CYCLES must be in 1..65535");
        end
    endgenerate

    logic [CNT1_W-1:0] div1_cnt_r;
    logic [CNT2_W-1:0] div2_cnt_r;
    logic [15:0]       lock_cnt_r;
    logic              run_s;

    // The gated build keys off the registered lock flag, so counting begins the edge after lock.
`ifdef CLK_WIZ_OUT_GATE_EN
    assign run_s = locked;
`else
    assign run_s = 1'b1;
`endif

    // Divider 1: count to DIV1/2-1, then wrap and toggle clk_out1.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            div1_cnt_r <= {CNT1_W{1'b0}};
            clk_out1   <= 1'b0;
        end else if (run_s) begin
            if (div1_cnt_r == TERM1) begin
                div1_cnt_r <= {CNT1_W{1'b0}};
                clk_out1   <= ~clk_out1;
            end else begin
                div1_cnt_r <= div1_cnt_r + CNT1_W'(1);
            end
        end else begin
            div1_cnt_r <= {CNT1_W{1'b0}};
            clk_out1   <= 1'b0;
        end
    end

    // Divider 2: same scheme as divider 1 with its own ratio.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            div2_cnt_r <= {CNT2_W{1'b0}};
            clk_out2   <= 1'b0;
        end else if (run_s) begin
            if (div2_cnt_r == TERM2) begin
                div2_cnt_r <= {CNT2_W{1'b0}};
                clk_out2   <= ~clk_out2;
            end else begin
                div2_cnt_r <= div2_cnt_r + CNT2_W'(1);
            end
        end else begin
            div2_cnt_r <= {CNT2_W{1'b0}};
            clk_out2   <= 1'b0;
        end
    end

    // Lock timer: saturating count of edges since reset release; locked is sticky until reset.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            lock_cnt_r <= 16'd0;
            locked     <= 1'b0;
        end else if (!locked) begin
            if (lock_cnt_r != 16'hFFFF) begin
                lock_cnt_r <= lock_cnt_r + 16'd1;
            end else begin
                lock_cnt_r <= lock_cnt_r;
            end
            if ((lock_cnt_r + 16'd1) == LOCK_TGT) begin
                locked <= 1'b1;
            end else begin
                locked <= 1'b0;
            end
        end else begin
            lock_cnt_r <= lock_cnt_r;
            locked     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clk_wiz.sv
// Self-checking bench for clk_wiz: three configurations share one reference clock and reset.
module tb_clk_wiz;

    logic clk = 1'b0;
    logic rst_n;

    logic o1_a, o2_a, lk_a;
    logic o1_b, o2_b, lk_b;
    logic o1_c, o2_c, lk_c;

    int checks = 0;
    int errors = 0;

`ifdef CLK_WIZ_OUT_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    typedef struct {
        int         k;
        logic [2:0] v;
    } exp_t;

    exp_t sb[$];

    clk_wiz u_def (
        .clk_in1 (clk),
        .reset   (rst_n),
        .clk_out1(o1_a),
        .clk_out2(o2_a),
        .locked  (lk_a)
    );

    clk_wiz #(.DIV1(6), .DIV2(10), .LOCK_CYCLES(16)) u_div (
        .clk_in1 (clk),
        .reset   (rst_n),
        .clk_out1(o1_b),
        .clk_out2(o2_b),
        .locked  (lk_b)
    );

    clk_wiz #(.DIV1(2), .DIV2(4), .LOCK_CYCLES(1)) u_lk1 (
        .clk_in1 (clk),
        .reset   (rst_n),
        .clk_out1(o1_c),
        .clk_out2(o2_c),
        .locked  (lk_c)
    );

    always #5 clk = ~clk;

    // Expected divided-clock level just after edge k (edge 1 = first edge after release).
    function automatic logic exp_div(int k, int div, int lock);
        int kk;
        kk = GATE ? (k - lock) : k;
        if (kk <= 0) return 1'b0;
        return (((kk / (div / 2)) % 2) == 1);
    endfunction

    function automatic logic exp_lock(int k, int lock);
        return (k >= lock);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            got = {o1_a, o2_a, lk_a, o1_b, o2_b, lk_b, o1_c, o2_c, lk_c};
            checks++;
            if (got !== 9'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %b expected %b", i, got, 9'b0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_defaults();
        exp_t e;
        logic [2:0] got;
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            sb.push_back('{k, {exp_div(k, 2, 16), exp_div(k, 4, 16), exp_lock(k, 16)}});
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {o1_a, o2_a, lk_a};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL defaults edge %0d: got %b expected %b", e.k, got, e.v);
            end
        end
    endtask

    task automatic test_div_6_10();
        exp_t e;
        logic [2:0] got;
        apply_reset();
        for (int k = 1; k <= 60; k++) begin
            sb.push_back('{k, {exp_div(k, 6, 16), exp_div(k, 10, 16), exp_lock(k, 16)}});
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {o1_b, o2_b, lk_b};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL div_6_10 edge %0d: got %b expected %b", e.k, got, e.v);
            end
        end
    endtask

    task automatic test_lock_one();
        exp_t e;
        logic [2:0] got;
        apply_reset();
        for (int k = 1; k <= 100; k++) begin
            sb.push_back('{k, {exp_div(k, 2, 1), exp_div(k, 4, 1), exp_lock(k, 1)}});
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {o1_c, o2_c, lk_c};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL lock_one edge %0d: got %b expected %b", e.k, got, e.v);
            end
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        logic [2:0] got;
        logic [8:0] all;
        apply_reset();
        for (int k = 1; k <= 25; k++) begin
            sb.push_back('{k, {exp_div(k, 2, 16), exp_div(k, 4, 16), exp_lock(k, 16)}});
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {o1_a, o2_a, lk_a};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL midrun_pre edge %0d: got %b expected %b", e.k, got, e.v);
            end
        end
        // Assert reset between edges; outputs must clear without another clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        all = {o1_a, o2_a, lk_a, o1_b, o2_b, lk_b, o1_c, o2_c, lk_c};
        checks++;
        if (all !== 9'b0) begin
            errors++;
            $display("FAIL midrun_async_clear: got %b expected %b", all, 9'b0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            sb.push_back('{k, {exp_div(k, 2, 16), exp_div(k, 4, 16), exp_lock(k, 16)}});
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {o1_a, o2_a, lk_a};
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL midrun_post edge %0d: got %b expected %b", e.k, got, e.v);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_defaults();
        test_div_6_10();
        test_lock_one();
        test_reset_midrun();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected %0d", sb.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
